// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: state encoding,
// cause-class codes, and default handler/return addressing.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4,
        ST_HALT     = 3'd5
    } trap_state_e;

    localparam logic [2:0] CAUSE_LOAD   = 3'b000;
    localparam logic [2:0] CAUSE_STORE  = 3'b001;
    localparam logic [2:0] CAUSE_ALUOP  = 3'b010;
    localparam logic [2:0] CAUSE_BRANCH = 3'b011;
    localparam logic [2:0] CAUSE_OPCODE = 3'b100;

    localparam logic [14:0] STVEC_DEFAULT      = 15'h1000;
    localparam int          RET_OFFSET_DEFAULT = 4;

endpackage

// File: rtl/trap_csr.sv
// SEPC/SCAUSE capture registers with a single load enable; kept separate so
// the CSR-read path can reuse them.
module trap_csr #(
    parameter int PC_W    = 15,
    parameter int CAUSE_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [PC_W-1:0]    sepc_i,
    input  logic [CAUSE_W-1:0] scause_i,
    output logic [PC_W-1:0]    sepc_o,
    output logic [CAUSE_W-1:0] scause_o
);

    logic [PC_W-1:0]    sepc_q;
    logic [CAUSE_W-1:0] scause_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sepc_q   <= '0;
            scause_q <= '0;
        end else if (load_i) begin
            sepc_q   <= sepc_i;
            scause_q <= scause_i;
        end
    end

    assign sepc_o   = sepc_q;
    assign scause_o = scause_q;

endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: latch CSRs, flush, redirect to STVEC, track handler, return
// on sret. Define TRAP_STATS_EN to enable the saturating trap_count counter.
module trap_controller
    import trap_pkg::*;
#(
    parameter int              PC_W         = 15,
    parameter int              CAUSE_W      = 64,
    parameter logic [PC_W-1:0] STVEC        = STVEC_DEFAULT,
    parameter int              FLUSH_CYCLES = 2,
    parameter int              RET_OFFSET   = RET_OFFSET_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exception,
    input  logic [PC_W-1:0]    sepc,
    input  logic [CAUSE_W-1:0] scause,
    input  logic               sret,
    output logic               flush,
    output logic               pc_redirect,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               in_trap,
    output logic               double_fault,
    output logic [PC_W-1:0]    sepc_q,
    output logic [CAUSE_W-1:0] scause_q,
    output logic [2:0]         cause_class,
    output logic [7:0]         trap_count
);

    trap_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        csr_load;

    trap_csr #(
        .PC_W    (PC_W),
        .CAUSE_W (CAUSE_W)
    ) u_csr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (csr_load),
        .sepc_i   (sepc),
        .scause_i (scause),
        .sepc_o   (sepc_q),
        .scause_o (scause_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        csr_load     = 1'b0;
        flush        = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = '0;
        in_trap      = 1'b0;
        double_fault = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exception) begin
                    csr_load = 1'b1;
                    cnt_d    = 3'(FLUSH_CYCLES);
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (cnt_q <= 3'd1) state_d = ST_REDIRECT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_REDIRECT: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = STVEC;
                state_d     = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_trap = 1'b1;
                // A second fault inside the handler wins over a simultaneous sret.
                if (exception) state_d = ST_HALT;
                else if (sret) state_d = ST_RETURN;
            end
            ST_RETURN: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = sepc_q + PC_W'(RET_OFFSET);
                in_trap     = 1'b1;
                state_d     = ST_RUN;
            end
            ST_HALT: begin
                flush        = 1'b1;
                in_trap      = 1'b1;
                double_fault = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign cause_class = scause_q[CAUSE_W-1 -: 3];

`ifdef TRAP_STATS_EN
    logic [7:0] trap_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    trap_count_q <= '0;
        else if (csr_load && trap_count_q != 8'hFF) trap_count_q <= trap_count_q + 8'd1;
    end

    assign trap_count = trap_count_q;
`else
    assign trap_count = '0;
`endif

endmodule
